// File: rtl/gf1291_pkg.sv
// Shared constants and types for GF(1291) arithmetic:
// the modulus, the Barrett parameters and the residue/product widths.
package gf1291_pkg;

    localparam int unsigned Q     = 1291;
    localparam int unsigned MU    = 3248;
    localparam int unsigned RW    = 11;
    localparam int unsigned PW    = 21;
    localparam int unsigned SHIFT = 11;

    typedef logic [RW-1:0] residue_t;
    typedef logic [PW-1:0] prod_t;

endpackage : gf1291_pkg

// File: rtl/mod1291_reduce_full.sv
// Combinational Barrett reduction of a 21-bit product mod 1291.
// The estimated quotient can fall short by up to 3, so three conditional subtractions follow.
module mod1291_reduce_full
    import gf1291_pkg::*;
(
    input  prod_t    x_i,
    output residue_t r_o
);

    localparam int unsigned HW = PW - SHIFT;
    localparam int unsigned XW = PW + 3;

    logic [HW-1:0] hi_c;
    logic [RW-1:0] t_c;
    logic [XW-1:0] r0_c;
    logic [XW-1:0] r1_c;
    logic [XW-1:0] r2_c;

    assign hi_c = x_i[PW-1:SHIFT];
    assign t_c  = RW'((XW'(hi_c) * XW'(MU)) >> SHIFT);

    // Raw remainder lies in [0, 4*Q-1]; never negative because t underestimates.
    assign r0_c = XW'(x_i) - (XW'(t_c) * XW'(Q));
    assign r1_c = (r0_c >= XW'(Q)) ? r0_c - XW'(Q) : r0_c;
    assign r2_c = (r1_c >= XW'(Q)) ? r1_c - XW'(Q) : r1_c;
    assign r_o  = (r2_c >= XW'(Q)) ? residue_t'(r2_c - XW'(Q)) : residue_t'(r2_c);

endmodule : mod1291_reduce_full

// File: rtl/mulmod_mac_1291.sv
// Streaming multiply-accumulate mod 1291: S1 multiply/range-check, S2 reduce, S3 accumulate/emit.
// The pipeline freezes as a whole whenever a held result is not being taken.
module mulmod_mac_1291
    import gf1291_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_a,
    input  logic [RW-1:0] in_b,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic          out_err
);

    localparam int unsigned SW = RW + 1;

    logic     advance_c;

    logic     v1_q, v1_d;
    logic     e1_q, e1_d;
    logic     l1_q, l1_d;
    prod_t    p1_q, p1_d;

    logic     v2_q, v2_d;
    logic     e2_q, e2_d;
    logic     l2_q, l2_d;
    residue_t r2_q, r2_d;
    residue_t red_c;

    residue_t acc_q, acc_d;
    logic     err_acc_q, err_acc_d;
    logic     out_valid_q, out_valid_d;
    residue_t out_data_q, out_data_d;
    logic     out_err_q, out_err_d;

    logic [SW-1:0] sum_c;
    residue_t      s_c;
    logic          verr_c;

    assign advance_c = !out_valid_q || out_ready;
    assign in_ready  = advance_c && !rst;

    // S1: capture operands, flag out-of-range beats and zero their product.
    always_comb begin
        v1_d = v1_q;
        e1_d = e1_q;
        l1_d = l1_q;
        p1_d = p1_q;
        if (advance_c) begin
            v1_d = in_valid && in_ready;
            e1_d = (in_a >= RW'(Q)) || (in_b >= RW'(Q));
            l1_d = in_last;
            p1_d = e1_d ? '0 : prod_t'(prod_t'(in_a) * prod_t'(in_b));
        end
    end

    mod1291_reduce_full u_reduce (
        .x_i (p1_q),
        .r_o (red_c)
    );

    // S2: register the reduced product alongside its control bits.
    always_comb begin
        v2_d = v2_q;
        e2_d = e2_q;
        l2_d = l2_q;
        r2_d = r2_q;
        if (advance_c) begin
            v2_d = v1_q;
            e2_d = e1_q;
            l2_d = l1_q;
            r2_d = red_c;
        end
    end

    assign sum_c  = SW'(acc_q) + SW'(r2_q);
    assign s_c    = (sum_c >= SW'(Q)) ? residue_t'(sum_c - SW'(Q)) : residue_t'(sum_c);
    assign verr_c = err_acc_q || e2_q;

    // S3: accumulate, or on the last beat emit the sum and restart from zero.
    always_comb begin
        acc_d       = acc_q;
        err_acc_d   = err_acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (advance_c) begin
            out_valid_d = v2_q && l2_q;
            if (v2_q) begin
                if (l2_q) begin
                    out_data_d = s_c;
                    out_err_d  = verr_c;
                    acc_d      = '0;
                    err_acc_d  = 1'b0;
                end else begin
                    acc_d     = s_c;
                    err_acc_d = verr_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            e1_q        <= 1'b0;
            l1_q        <= 1'b0;
            p1_q        <= '0;
            v2_q        <= 1'b0;
            e2_q        <= 1'b0;
            l2_q        <= 1'b0;
            r2_q        <= '0;
            acc_q       <= '0;
            err_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            e1_q        <= e1_d;
            l1_q        <= l1_d;
            p1_q        <= p1_d;
            v2_q        <= v2_d;
            e2_q        <= e2_d;
            l2_q        <= l2_d;
            r2_q        <= r2_d;
            acc_q       <= acc_d;
            err_acc_q   <= err_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule : mulmod_mac_1291

// File: tb/tb_mulmod_mac_1291.sv
// Directed bench for mulmod_mac_1291 and its Barrett reduction sub-module.
module tb_mulmod_mac_1291;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_a;
    logic [10:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_err;

    logic [20:0] red_x;
    logic [10:0] red_r;

    int checks;
    int errors;

    logic [11:0] resq[$];

    mulmod_mac_1291 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    mod1291_reduce_full u_red (
        .x_i (red_x),
        .r_o (red_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result handshake in order.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            resq.push_back({out_err, out_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic drive_beat(input int a, input int b, input bit last);
        int n;
        in_valid = 1'b1;
        in_a     = 11'(a);
        in_b     = 11'(b);
        in_last  = last;
        n = 0;
        #2;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL drive_beat_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input int exp_data, input bit exp_err);
        int n;
        logic [11:0] r;
        n = 0;
        while (resq.size() == 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (resq.size() == 0) begin
            errors++;
            $display("FAIL %s: no result observed, required data=%0d err=%0b", name, exp_data, exp_err);
        end else begin
            r = resq.pop_front();
            if (r !== {exp_err, 11'(exp_data)}) begin
                errors++;
                $display("FAIL %s: data=%0d err=%0b required data=%0d err=%0b",
                         name, r[10:0], r[11], exp_data, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%0b required=0", in_ready);
        end
        step();
        checks++;
        if ({out_valid, out_data, out_err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b data=%0d err=%0b required 0/0/0",
                     out_valid, out_data, out_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: in_ready=%0b required=1", in_ready);
        end
        step();
    endtask

    task automatic test_reduce_sweep();
        int bad;
        int exp;
        bad = 0;
        for (int x = 0; x <= 1290 * 1290; x++) begin
            red_x = 21'(x);
            #1;
            exp = x % 1291;
            if (red_r !== 11'(exp)) begin
                if (bad < 4)
                    $display("FAIL reduce_sweep x=%0d: r=%0d required=%0d", x, red_r, exp);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reduce_sweep_total: %0d wrong residues, required 0", bad);
        end
    endtask

    // Checks exact latency: result visible after the second edge following acceptance.
    task automatic test_single_beat();
        in_valid = 1'b1;
        in_a     = 11'd1290;
        in_b     = 11'd1290;
        in_last  = 1'b1;
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%0b required=0 after edge k", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_k1: out_valid=%0b required=0 after edge k+1", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL latency_k2: valid=%0b data=%0d err=%0b required 1/1/0",
                     out_valid, out_data, out_err);
        end
        expect_result("single_1290sq", 1, 1'b0);
        drive_beat(1000, 1000, 1'b1);
        expect_result("single_1000sq", 766, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_beat(1, 1, 1'b0);
        drive_beat(2, 3, 1'b0);
        drive_beat(1290, 1290, 1'b1);
        drive_beat(5, 7, 1'b1);
        expect_result("vec_sum8", 8, 1'b0);
        expect_result("vec_b2b_35", 35, 1'b0);
    endtask

    task automatic test_error();
        drive_beat(1291, 5, 1'b0);
        drive_beat(3, 4, 1'b1);
        drive_beat(2, 2, 1'b1);
        expect_result("err_vec", 12, 1'b1);
        expect_result("err_cleared", 4, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [10:0] held;
        int          n;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    drive_beat(k + 1, k + 2, 1'b1);
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    step();
                    n++;
                end
                out_ready = 1'b0;
                held = out_data;
                #1;
                for (int c = 0; c < 5; c++) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_in_ready cycle %0d: in_ready=%0b required=0", c, in_ready);
                    end
                    @(posedge clk);
                    #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== held) begin
                        errors++;
                        $display("FAIL bp_hold cycle %0d: valid=%0b data=%0d required 1/%0d",
                                 c, out_valid, out_data, held);
                    end
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 6; k++)
            expect_result($sformatf("bp_result_%0d", k), ((k + 1) * (k + 2)) % 1291, 1'b0);
        repeat (6) step();
        checks++;
        if (resq.size() != 0) begin
            errors++;
            $display("FAIL bp_extra: %0d extra results, required 0", resq.size());
        end
    endtask

    task automatic test_reset_mid_vector();
        drive_beat(10, 10, 1'b0);
        drive_beat(20, 20, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_beat(3, 3, 1'b1);
        expect_result("rst_mid_vector", 9, 1'b0);
        repeat (6) step();
        checks++;
        if (resq.size() != 0) begin
            errors++;
            $display("FAIL rst_extra: %0d extra results, required 0", resq.size());
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        red_x     = '0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_error();
        test_backpressure();
        test_reset_mid_vector();
        test_reduce_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mulmod_mac_1291
